// File: rtl/pn_sync_pkg.sv
// pn_sync_pkg: constants and types shared by the PN acquisition controller.
//   EnergyW      - width of the correlator energy and threshold words
//   AddrW        - width of the PN code phase address
//   acq_state_e  - acquisition FSM state encoding (also exported on the debug port)
//   nofm_flags_t - decision flags produced by the N-of-M counter
//   next_phase   - code phase increment with wrap at the last position
package pn_sync_pkg;

    localparam int unsigned EnergyW = 36;
    localparam int unsigned AddrW   = 8;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StSettle = 2'd1,
        StVerify = 2'd2,
        StTrack  = 2'd3
    } acq_state_e;

    typedef struct packed {
        logic done;  // trial count has reached the window length
        logic met;   // hit count has reached the threshold
    } nofm_flags_t;

    function automatic logic [AddrW-1:0] next_phase(input logic [AddrW-1:0] addr,
                                                    input logic [AddrW-1:0] last);
        return (addr == last) ? '0 : addr + AddrW'(1);
    endfunction

endpackage

// File: rtl/pn_acq_ctrl_if.sv
// pn_acq_ctrl_if: correlator-side bundle of the PN acquisition controller.
//   dump      - one-cycle end-of-integration pulse (master -> slave)
//   energy    - mid-correlator energy, valid with dump (master -> slave)
//   gate      - detection threshold, sampled with dump (master -> slave)
//   load      - one-cycle PN generator load command (slave -> master)
//   addr_load - code phase to load (slave -> master)
//   locked    - high while tracking (slave -> master)
//   state     - debug view of the FSM state (slave -> master)
interface pn_acq_ctrl_if;
    import pn_sync_pkg::*;

    logic               dump;
    logic [EnergyW-1:0] energy;
    logic [EnergyW-1:0] gate;
    logic               load;
    logic [AddrW-1:0]   addr_load;
    logic               locked;
    logic [1:0]         state;

    modport master (
        output dump, energy, gate,
        input  load, addr_load, locked, state
    );

    modport slave (
        input  dump, energy, gate,
        output load, addr_load, locked, state
    );

endinterface

// File: rtl/pn_nofm_cnt.sv
// pn_nofm_cnt: pair of saturating counters for an N-of-M decision.
//   clk_i, rst_i - clock and synchronous active-high reset
//   clr_i        - discard the current window; a simultaneous step starts a new one
//   step_i       - count one trial
//   hit_i        - the counted trial was a hit (qualified by step_i)
//   flags_o      - decisions on the post-update counts (same cycle as step_i)
// Counters are $clog2(WinLen+1) bits wide and saturate at WinLen. Thresh must not
// exceed WinLen.
module pn_nofm_cnt
    import pn_sync_pkg::*;
#(
    parameter int unsigned WinLen = 4,
    parameter int unsigned Thresh = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        step_i,
    input  logic        hit_i,
    output nofm_flags_t flags_o
);

    localparam int unsigned CntW = $clog2(WinLen + 1);
    localparam logic [CntW-1:0] WinMax = CntW'(WinLen);
    localparam logic [CntW-1:0] ThrVal = CntW'(Thresh);

    logic [CntW-1:0] trials_q, trials_d;
    logic [CntW-1:0] hits_q, hits_d;
    logic [CntW-1:0] trials_base, hits_base;

    always_comb begin
        trials_base = clr_i ? '0 : trials_q;
        hits_base   = clr_i ? '0 : hits_q;
        trials_d    = trials_base;
        hits_d      = hits_base;
        if (step_i) begin
            if (trials_base != WinMax) begin
                trials_d = trials_base + CntW'(1);
            end
            if (hit_i && (hits_base != WinMax)) begin
                hits_d = hits_base + CntW'(1);
            end
        end
        flags_o.done = (trials_d >= WinMax);
        flags_o.met  = (hits_d >= ThrVal);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trials_q <= '0;
            hits_q   <= '0;
        end else begin
            trials_q <= trials_d;
            hits_q   <= hits_d;
        end
    end

endmodule

// File: rtl/pn_acq_ctrl.sv
// pn_acq_ctrl: PN code acquisition controller (serial search, N-of-M verify, track).
//   clk - system clock
//   rst - synchronous active-high reset
//   bus - correlator bundle (slave side): dump/energy/gate in,
//         load/addr_load/locked/state out; all outputs registered (latency 1)
module pn_acq_ctrl
    import pn_sync_pkg::*;
#(
    parameter int unsigned PN_LEN   = 255,
    parameter int unsigned VERIFY_M = 4,
    parameter int unsigned VERIFY_N = 3,
    parameter int unsigned LOSS_K   = 8
) (
    input logic           clk,
    input logic           rst,
    pn_acq_ctrl_if.slave  bus
);

    localparam logic [AddrW-1:0] LastPhase = AddrW'(PN_LEN - 1);

    acq_state_e       state_q, state_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic             load_q, load_d;
    logic             locked_q, locked_d;

    logic        ge;
    logic        hit;
    logic        miss;
    logic        phase_step;
    nofm_flags_t vfy_flags;
    nofm_flags_t loss_flags;

    assign ge   = (bus.energy >= bus.gate);
    assign hit  = bus.dump & ge;
    assign miss = bus.dump & ~ge;

    // Verify window: opened by the SEARCH hit (clear + step gives 1 trial, 1 hit),
    // then counts every dump while in VERIFY.
    pn_nofm_cnt #(
        .WinLen (VERIFY_M),
        .Thresh (VERIFY_N)
    ) u_vfy_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (state_q != StVerify),
        .step_i  ((hit && (state_q == StSearch)) || (bus.dump && (state_q == StVerify))),
        .hit_i   (ge),
        .flags_o (vfy_flags)
    );

    // Loss detector: K-of-K misses, with any hit restarting the window, i.e. K
    // consecutive misses.
    pn_nofm_cnt #(
        .WinLen (LOSS_K),
        .Thresh (LOSS_K)
    ) u_loss_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   ((state_q != StTrack) || hit),
        .step_i  (miss && (state_q == StTrack)),
        .hit_i   (1'b1),
        .flags_o (loss_flags)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        load_d     = 1'b0;
        phase_step = 1'b0;

        if (bus.dump) begin
            unique case (state_q)
                StSearch: begin
                    if (ge) begin
                        state_d = vfy_flags.met ? StTrack : StVerify;
                    end else begin
                        phase_step = 1'b1;
                    end
                end
                // First dump after a load integrated across the phase jump.
                StSettle: state_d = StSearch;
                StVerify: begin
                    if (vfy_flags.met) begin
                        state_d = StTrack;
                    end else if (vfy_flags.done) begin
                        phase_step = 1'b1;
                    end
                end
                StTrack: begin
                    if (loss_flags.met && loss_flags.done) begin
                        phase_step = 1'b1;
                    end
                end
                default: state_d = StSearch;
            endcase
        end

        if (phase_step) begin
            addr_d  = next_phase(addr_q, LastPhase);
            load_d  = 1'b1;
            state_d = StSettle;
        end

        locked_d = (state_d == StTrack);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StSearch;
            addr_q   <= '0;
            load_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            load_q   <= load_d;
            locked_q <= locked_d;
        end
    end

    assign bus.load      = load_q;
    assign bus.addr_load = addr_q;
    assign bus.locked    = locked_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_pn_acq_ctrl.sv
module tb_pn_acq_ctrl;
    import pn_sync_pkg::*;

    localparam int PN = 255;
    localparam int M  = 4;
    localparam int N  = 3;
    localparam int K  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pn_acq_ctrl_if bus_if ();

    pn_acq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic [1:0] state;
        logic [7:0] addr;
        logic       load;
        logic       locked;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   load_cnt = 0;
    logic locked_seen;

    // Reference model state
    acq_state_e m_state;
    int         m_addr, m_hits, m_dumps, m_miss;
    logic       m_load;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_phase_step();
        m_addr  = (m_addr == PN - 1) ? 0 : m_addr + 1;
        m_load  = 1'b1;
        m_state = StSettle;
    endtask

    task automatic model(input logic r, input logic d, input logic h);
        if (r) begin
            m_state = StSearch; m_addr = 0; m_load = 1'b0;
            m_hits = 0; m_dumps = 0; m_miss = 0;
        end else begin
            m_load = 1'b0;
            if (d) begin
                case (m_state)
                    StSearch: begin
                        if (h) begin m_state = StVerify; m_hits = 1; m_dumps = 1; end
                        else model_phase_step();
                    end
                    StSettle: m_state = StSearch;
                    StVerify: begin
                        m_dumps++;
                        if (h) m_hits++;
                        if (m_hits >= N) begin m_state = StTrack; m_miss = 0; end
                        else if (m_dumps >= M) model_phase_step();
                    end
                    default: begin
                        if (h) m_miss = 0;
                        else begin
                            m_miss++;
                            if (m_miss >= K) model_phase_step();
                        end
                    end
                endcase
            end
        end
    endtask

    // One clock: drive inputs, push the model's expectation, compare after the edge.
    task automatic cyc(input logic r, input logic d, input logic [35:0] e, input logic [35:0] g);
        exp_t x;
        @(negedge clk);
        rst = r; bus_if.dump = d; bus_if.energy = e; bus_if.gate = g;
        model(r, d, e >= g);
        x.state = m_state; x.addr = 8'(m_addr); x.load = m_load; x.locked = (m_state == StTrack);
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("sb_state", 32'(bus_if.state), 32'(x.state));
        chk("sb_addr", 32'(bus_if.addr_load), 32'(x.addr));
        chk("sb_load", 32'(bus_if.load), 32'(x.load));
        chk("sb_locked", 32'(bus_if.locked), 32'(x.locked));
        if (bus_if.load === 1'b1) load_cnt++;
        if (bus_if.locked !== 1'b0) locked_seen = 1'b1;
    endtask

    // Miss in SEARCH (phase step) followed by the SETTLE discard.
    task automatic search_miss();
        cyc(1'b0, 1'b1, 36'd0, 36'd100);
        cyc(1'b0, 1'b1, 36'd0, 36'd100);
    endtask

    initial begin
        rst = 1'b1; bus_if.dump = 1'b0; bus_if.energy = '0; bus_if.gate = 36'd100;

        // Reset
        cyc(1'b1, 1'b0, 36'd0, 36'd100);
        cyc(1'b1, 1'b1, 36'd500, 36'd100);
        chk("rst_state", 32'(bus_if.state), 32'(StSearch));
        chk("rst_addr", 32'(bus_if.addr_load), 32'd0);
        chk("rst_load", 32'(bus_if.load), 32'd0);
        chk("rst_locked", 32'(bus_if.locked), 32'd0);

        // Full search sweep, wrapping at 254 -> 0
        load_cnt = 0; locked_seen = 1'b0;
        for (int i = 0; i < PN; i++) begin
            if (i == PN - 1) chk("pre_wrap_addr", 32'(bus_if.addr_load), 32'd254);
            cyc(1'b0, 1'b1, 36'd0, 36'd100);
            if (i == PN - 1) begin
                chk("wrap_addr", 32'(bus_if.addr_load), 32'd0);
                chk("wrap_load", 32'(bus_if.load), 32'd1);
            end
            cyc(1'b0, 1'b1, 36'd0, 36'd100);
        end
        chk("sweep_loads", 32'(load_cnt), 32'd255);
        chk("sweep_addr", 32'(bus_if.addr_load), 32'd0);
        chk("sweep_locked", 32'(locked_seen), 32'd0);

        // Failed verify at 37: hit, miss, miss, hit
        for (int i = 0; i < 37; i++) search_miss();
        chk("pre_fv_addr", 32'(bus_if.addr_load), 32'd37);
        cyc(1'b0, 1'b1, 36'd100, 36'd100);  // energy == gate is a hit
        chk("fv_state1", 32'(bus_if.state), 32'(StVerify));
        cyc(1'b0, 1'b1, 36'd99, 36'd100);
        cyc(1'b0, 1'b1, 36'd0, 36'd100);
        cyc(1'b0, 1'b1, 36'd500, 36'd100);
        chk("fv_load", 32'(bus_if.load), 32'd1);
        chk("fv_addr", 32'(bus_if.addr_load), 32'd38);
        chk("fv_state", 32'(bus_if.state), 32'(StSettle));

        // Acquisition at 37
        cyc(1'b1, 1'b0, 36'd0, 36'd100);
        for (int i = 0; i < 37; i++) search_miss();
        load_cnt = 0;
        cyc(1'b0, 1'b1, 36'd400, 36'd100);
        cyc(1'b0, 1'b1, 36'd400, 36'd100);
        chk("acq_not_yet", 32'(bus_if.locked), 32'd0);
        cyc(1'b0, 1'b1, 36'd400, 36'd100);
        chk("acq_state", 32'(bus_if.state), 32'(StTrack));
        chk("acq_locked", 32'(bus_if.locked), 32'd1);
        cyc(1'b0, 1'b1, 36'd400, 36'd100);
        chk("acq_no_load", 32'(load_cnt), 32'd0);

        // Gate changes without a dump leave the state alone
        cyc(1'b0, 1'b0, 36'd0, 36'd50);
        cyc(1'b0, 1'b0, 36'd0, 36'd5000);
        chk("gate_chg_state", 32'(bus_if.state), 32'(StTrack));
        cyc(1'b0, 1'b1, 36'd150, 36'd200);  // new gate applies: a miss
        cyc(1'b0, 1'b1, 36'd300, 36'd200);

        // Loss of lock: 7 misses, 1 hit, 8 misses
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 36'd10, 36'd200);
        chk("loss_7a", 32'(bus_if.locked), 32'd1);
        cyc(1'b0, 1'b1, 36'd300, 36'd200);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 36'd10, 36'd200);
        chk("loss_7b", 32'(bus_if.locked), 32'd1);
        cyc(1'b0, 1'b1, 36'd10, 36'd200);
        chk("loss_locked", 32'(bus_if.locked), 32'd0);
        chk("loss_load", 32'(bus_if.load), 32'd1);
        chk("loss_addr", 32'(bus_if.addr_load), 32'd38);
        cyc(1'b0, 1'b1, 36'd999, 36'd200);  // discard, even though a hit

        // Lock at 200 then reset mid-TRACK
        for (int i = 0; i < 162; i++) search_miss();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 36'd400, 36'd100);
        chk("t200_addr", 32'(bus_if.addr_load), 32'd200);
        chk("t200_locked", 32'(bus_if.locked), 32'd1);
        cyc(1'b1, 1'b1, 36'd0, 36'd100);
        chk("rtrk_addr", 32'(bus_if.addr_load), 32'd0);
        chk("rtrk_locked", 32'(bus_if.locked), 32'd0);
        chk("rtrk_load", 32'(bus_if.load), 32'd0);
        chk("rtrk_state", 32'(bus_if.state), 32'(StSearch));

        // First dump after reset is judged in SEARCH; reset mid-VERIFY issues no load
        cyc(1'b0, 1'b1, 36'd100, 36'd50);
        chk("post_rst_state", 32'(bus_if.state), 32'(StVerify));
        cyc(1'b1, 1'b1, 36'd0, 36'd50);
        chk("rvfy_load", 32'(bus_if.load), 32'd0);
        chk("rvfy_state", 32'(bus_if.state), 32'(StSearch));
        cyc(1'b0, 1'b1, 36'd0, 36'd50);
        chk("rvfy_step_addr", 32'(bus_if.addr_load), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
